dff_bist_checker: RTL and testbench

// - Synthesizable self-test harness for the d_flip_flop cell: the checking end of the D->Q interface.
// - Drives a pseudo-random bit stream onto the DUT D input and compares the returned Q/Qbar against a delayed expected copy.
// - Counts mismatches and reports PASS/DONE.
// - Sits beside any single-bit register cell in the DSD lab top; the same CLK clocks both harness and DUT.

---
 rtl/dff_bist_checker_pkg.sv | 28 ++
 rtl/dff_bist_checker_lfsr8.sv | 27 ++
 rtl/dff_bist_checker.sv | 127 ++++++++++++
 tb/tb_dff_bist_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bist_checker_pkg.sv
// dff_bist_pkg: shared types and constants for the
// single-bit register self-test harness.
package dff_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam int ERR_W = 8;
  localparam int VEC_W = 16;

  // One Fibonacci step: shift toward bit 0, feedback into bit 7.
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {^(s & LFSR_TAPS), s[7:1]};
  endfunction

endpackage

// File: rtl/dff_bist_checker_lfsr8.sv
// lfsr8: 8-bit Fibonacci stimulus generator.
// A load with en set yields the state after the seed.
module lfsr8
  import dff_bist_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] q
);

  // Load (optionally pre-stepped) or advance the register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= en ? lfsr_next(seed) : seed;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/dff_bist_checker.sv
// dff_bist_checker: drives LFSR bits into a register cell
// and scores the returned Q/Qbar against a delayed copy.
module dff_bist_checker
  import dff_bist_pkg::*;
#(
  parameter int         N_VECTORS = 16,
  parameter int         LAT       = 1,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic             D_OUT,
  input  logic             Q_IN,
  input  logic             QBAR_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [VEC_W-1:0] VEC_COUNT
);

  localparam logic [VEC_W-1:0] N_LAST = VEC_W'(N_VECTORS);
  localparam logic [2:0]       D_LAST = 3'(LAT);

  state_t     state;
  logic [2:0] drain_cnt;
  logic [7:0] lfsr_q;
  logic [LAT:0] pipe_v;
  logic [LAT:0] pipe_d;
  logic       go;
  logic       step;
  logic       drv_v;
  logic       drv_d;
  logic       mis;
  logic       unused_lfsr;

  assign go    = START &&
                 (state == S_IDLE || state == S_DONE);
  assign step  = (state == S_RUN) && (VEC_COUNT != N_LAST);
  assign drv_v = go || step;
  assign drv_d = go ? SEED[0] : lfsr_q[0];
  assign mis   = pipe_v[LAT] &&
                 ((Q_IN != pipe_d[LAT]) || (QBAR_IN == Q_IN));
  assign unused_lfsr = ^lfsr_q[7:1];

  lfsr8 #(
    .RST_VAL (SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (go),
    .seed  (SEED),
    .en    (drv_v),
    .q     (lfsr_q)
  );

  // Run sequencing with registered status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      D_OUT     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      VEC_COUNT <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_RUN;
            D_OUT     <= SEED[0];
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            VEC_COUNT <= VEC_W'(1);
          end
        end
        S_RUN: begin
          if (step) begin
            D_OUT     <= lfsr_q[0];
            VEC_COUNT <= VEC_COUNT + VEC_W'(1);
          end else begin
            state     <= S_DRAIN;
            D_OUT     <= 1'b0;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (ERR_COUNT == '0);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Expected-bit delay line, aligned with the cell latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_v <= '0;
      pipe_d <= '0;
    end else begin
      pipe_v <= {pipe_v[LAT-1:0], drv_v};
      pipe_d <= {pipe_d[LAT-1:0], drv_d};
    end
  end

  // Saturating mismatch counter, one hit per vector.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_COUNT <= '0;
    end else if (go) begin
      ERR_COUNT <= '0;
    end else if (mis && ERR_COUNT != {ERR_W{1'b1}}) begin
      ERR_COUNT <= ERR_COUNT + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_dff_bist_checker.sv
// tb_dff_bist_checker: harness runs against a modelled
// register cell with golden and broken return paths.
module tb_dff_bist_checker;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       d_out, q_in, qbar_in;
  logic       busy, done, pass;
  logic [7:0] err;
  logic [15:0] vec;

  logic       d_out3, q_in3, qbar_in3;
  logic       busy3, done3, pass3;
  logic [7:0] err3;
  logic [15:0] vec3;

  logic q_ff  = 1'b0;
  logic q3_ff = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) q_ff  <= d_out;
  always @(posedge CLK) q3_ff <= d_out3;

  always_comb begin
    q_in    = q_ff;
    qbar_in = ~q_ff;
    case (mode)
      2'd1: qbar_in = q_ff;
      2'd2: begin
        q_in    = ~q_ff;
        qbar_in = q_ff;
      end
      default: ;
    endcase
  end

  assign q_in3    = q3_ff;
  assign qbar_in3 = q3_ff;

  dff_bist_checker u_dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .D_OUT     (d_out),
    .Q_IN      (q_in),
    .QBAR_IN   (qbar_in),
    .BUSY      (busy),
    .DONE      (done),
    .PASS      (pass),
    .ERR_COUNT (err),
    .VEC_COUNT (vec)
  );

  dff_bist_checker #(
    .N_VECTORS (300)
  ) u_dut300 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (start3),
    .D_OUT     (d_out3),
    .Q_IN      (q_in3),
    .QBAR_IN   (qbar_in3),
    .BUSY      (busy3),
    .DONE      (done3),
    .PASS      (pass3),
    .ERR_COUNT (err3),
    .VEC_COUNT (vec3)
  );

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
  endfunction

  task automatic test_reset();
    #2;
    n_vec++;
    if ({d_out, busy, done, pass, err, vec} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0",
               {d_out, busy, done, pass, err, vec});
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    n_vec++;
    if (d_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_outputs got d=%b busy=%b want 0 0",
               d_out, busy);
    end
  endtask

  task automatic run_one(input logic [1:0] m,
                         input logic [7:0] exp_err,
                         input logic exp_pass,
                         input logic hold,
                         input string tag);
    logic [7:0] s;
    logic dbit;
    int edges;
    mode = m;
    s = 8'hA5;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(s[0]);
      s = nxt(s);
    end
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (exp_q.size() > 0) begin
        dbit = exp_q.pop_front();
        n_vec++;
        if (d_out !== dbit) begin
          n_err++;
          $display("FAIL %s d_out edge %0d got %b want %b",
                   tag, edges, d_out, dbit);
        end
      end else begin
        n_vec++;
        if (d_out !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s drain edge %0d got d=%b busy=%b want 0 1",
                   tag, edges, d_out, busy);
        end
      end
      @(posedge CLK); #1;
      edges++;
      if (hold && edges == 10) START = 1'b0;
    end
    START = 1'b0;
    n_vec++;
    if (edges != 18) begin
      n_err++;
      $display("FAIL %s done_latency got %0d want 18", tag, edges);
    end
    n_vec++;
    if (err !== exp_err || pass !== exp_pass) begin
      n_err++;
      $display("FAIL %s result got err=%0d pass=%b want err=%0d pass=%b",
               tag, err, pass, exp_err, exp_pass);
    end
    n_vec++;
    if (vec !== 16'd16 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s vec_count got %0d busy=%b want 16 0",
               tag, vec, busy);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (done !== 1'b1 || err !== exp_err || vec !== 16'd16) begin
      n_err++;
      $display("FAIL %s done_hold got done=%b err=%0d vec=%0d",
               tag, done, err, vec);
    end
  endtask

  task automatic test_golden();
    run_one(2'd0, 8'd0, 1'b1, 1'b0, "golden");
  endtask

  task automatic test_broken_complement();
    run_one(2'd1, 8'd16, 1'b0, 1'b0, "qbar_tied");
  endtask

  task automatic test_inverted_q();
    run_one(2'd2, 8'd16, 1'b0, 1'b0, "q_inverted");
  endtask

  task automatic test_back_to_back();
    run_one(2'd0, 8'd0, 1'b1, 1'b1, "start_held");
    run_one(2'd0, 8'd0, 1'b1, 1'b0, "restart");
  endtask

  task automatic test_saturation();
    int edges;
    @(negedge CLK);
    start3 = 1'b1;
    @(posedge CLK); #1;
    start3 = 1'b0;
    edges = 0;
    while (done3 !== 1'b1 && edges < 400) begin
      @(posedge CLK); #1;
      edges++;
    end
    n_vec++;
    if (edges != 302) begin
      n_err++;
      $display("FAIL sat_latency got %0d want 302", edges);
    end
    n_vec++;
    if (err3 !== 8'd255 || pass3 !== 1'b0) begin
      n_err++;
      $display("FAIL sat_err got err=%0d pass=%b want 255 0",
               err3, pass3);
    end
    n_vec++;
    if (vec3 !== 16'd300) begin
      n_err++;
      $display("FAIL sat_vec got %0d want 300", vec3);
    end
  endtask

  task automatic test_reset_abort();
    mode = 2'd1;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (6) @(posedge CLK);
    #2;
    n_vec++;
    if (busy !== 1'b1 || err === 8'd0) begin
      n_err++;
      $display("FAIL abort_pre got busy=%b err=%0d want 1 nonzero",
               busy, err);
    end
    RST_N = 1'b0;
    #1;
    n_vec++;
    if ({d_out, busy, done, pass, err, vec} !== 28'd0) begin
      n_err++;
      $display("FAIL abort_outputs got %h want 0",
               {d_out, busy, done, pass, err, vec});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    run_one(2'd0, 8'd0, 1'b1, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_golden();
    test_broken_complement();
    test_inverted_q();
    test_back_to_back();
    test_saturation();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
